// File: rtl/add_sub_serial.sv
// Digit-serial two's-complement adder/subtractor with start/busy/done handshake,
// optional signed saturation and carry/overflow/zero/negative status flags.
module add_sub_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             select,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] partial;
    logic             cin;
    logic             sat_q;
    logic             msb_a;
    logic             msb_b;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   digit_sum;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] final_res;
    logic             raw_ovf;

    // One digit of the ripple sum; the new digit enters at the top of the partial result.
    always_comb begin
        digit_sum = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + (DIGIT+1)'(cin);
        raw       = WIDTH'({digit_sum[DIGIT-1:0], partial} >> DIGIT);
        raw_ovf   = (msb_a == msb_b) && (raw[WIDTH-1] != msb_a);
        sat_val   = msb_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        final_res = (sat_q && raw_ovf) ? sat_val : raw;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            partial  <= '0;
            cin      <= 1'b0;
            sat_q    <= 1'b0;
            msb_a    <= 1'b0;
            msb_b    <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{select}};
                        cin   <= select;
                        sat_q <= sat;
                        msb_a <= a[WIDTH-1];
                        msb_b <= b[WIDTH-1] ^ select;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    op_a    <= op_a >> DIGIT;
                    op_b    <= op_b >> DIGIT;
                    cin     <= digit_sum[DIGIT];
                    partial <= raw;
                    cnt     <= cnt + CW'(1);
                    // Last digit: publish result and flags for exactly one done cycle.
                    if (cnt == CW'(N - 1)) begin
                        result   <= final_res;
                        carry    <= digit_sum[DIGIT];
                        overflow <= raw_ovf;
                        zero     <= (final_res == '0);
                        negative <= final_res[WIDTH-1];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/add_sub_serial.md
# add_sub_serial

Parametrised, multi-cycle two's-complement adder/subtractor that processes DIGIT bits per clock.
- It extends the fixed 4-bit combinational add/sub to any width and adds a start/busy/done handshake, selectable signed saturation, and status flags (carry, overflow, zero, negative).
- It serves as the area-lean arithmetic unit for datapaths that can tolerate WIDTH/DIGIT cycles of latency.

## Interface
- WIDTH, 8, operand/result width in bits; ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. DIGIT = WIDTH gives single-cycle operation.
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new operation; sampled only when not busy.
- a  input  WIDTH  first operand; captured on an accepted start.
- b  input  WIDTH  second operand; captured on an accepted start.
- select  input  1  captured on start; 0 = a + b, 1 = a − b.
- sat  input  1  captured on start; 1 = clamp signed overflow to the signed extreme.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result and flags are valid.
- result  output  WIDTH  sum/difference; held until the next done.
- carry  output  1  final carry-out. For subtract, 1 = no borrow (a ≥ b unsigned).
- overflow  output  1  signed overflow of the unsaturated result.
- zero  output  1  final result == 0.
- negative  output  1  final result MSB.

## Operation
- States:
  - IDLE: busy = 0.
  - RUN: busy = 1, with a digit counter 0 .. N−1, where N = WIDTH/DIGIT.
- IDLE, start = 1:
  - Capture A = a and B' = b ^ {WIDTH{select}}.
  - Set internal carry = select, capture sat, clear the counter.
  - Go to RUN.
- RUN, each cycle:
  - Add the low DIGIT bits of A, B', and carry.
  - Shift the sum digit into the top of the partial-result register.
  - Shift A and B' right by DIGIT and update carry.
  - Keep a copy of the operand MSBs (a[W−1], B'[W−1]) for overflow.
- RUN, final digit (counter == N−1):
  - raw = the complete partial result.
  - overflow = (a[W−1] == B'[W−1]) && (raw[W−1] != a[W−1]).
  - If sat && overflow: result = a[W−1] ? {1'b1, {W−1{0}}} : {1'b0, {W−1{1}}}. Otherwise result = raw.
  - carry = final carry-out. zero and negative are computed from the final (post-saturation) result.
  - Register all outputs, pulse done, return to IDLE.
- overflow reports the raw condition even when the result is saturated.
- start while busy is ignored; it is neither queued nor allowed to corrupt operands.
- Inputs a, b, select and sat may change freely after an accepted start.
- result and the flags change only on the done cycle. Between operations they hold their last values.

## Timing
- Reset (rst_n = 0 at an edge) forces IDLE and clears busy, done, result, carry, overflow, zero and negative to 0.
- Reset has priority over every other event. Reset during RUN aborts the operation with no done and outputs cleared.
- Start accepted at edge E0: busy = 1 from E0. Digits are processed at edges E1..EN. At EN, outputs are registered, done = 1 and busy = 0. At EN+1, done = 0.
- Latency from start edge to done is N cycles. With DIGIT = WIDTH this is 1 cycle.
- Back-to-back: start high in the done cycle is accepted at EN+1. Throughput is one operation per N+1 cycles.
- The done pulse is exactly one cycle and never occurs without a preceding accepted start.

## Test plan
- WIDTH=4, DIGIT=1: a=4'b1101, b=4'b0001, select=0, start.
  - Required: done after 4 cycles with result=4'b1110, carry=0, overflow=0, negative=1, zero=0.
  - Repeat with select=1. Required: result=4'b1100, carry=1, overflow=0.
- WIDTH=8, DIGIT=1: a=8'h7F, b=8'h01, add.
  - With sat=0: result=8'h80, overflow=1.
  - With sat=1: result=8'h7F, overflow=1, negative=0.
  - a=8'h80, b=8'h01, subtract, sat=1: result=8'h80, overflow=1.
- WIDTH=8: a=8'h05 − b=8'h05 gives 8'h00 with zero=1, carry=1. a=8'h03 − b=8'h05 gives 8'hFE with carry=0, negative=1.
- WIDTH=8, DIGIT=2:
  - Done arrives exactly 4 cycles after start.
  - A second start held high during busy is ignored.
  - A start in the done cycle is accepted and yields the correct second result.
- Reset mid-RUN (rst_n low at cycle 2 of 8): no done pulse, all outputs 0. A following operation completes correctly.
- Randomised sweep over WIDTH ∈ {4, 8, 16} with every legal DIGIT: result and flags match a reference model for 1000 operations per configuration.
